gamepad_pmod_transmitter: RTL and testbench

Controller-side end of the 3-wire gamepad PMOD link. It serialises a BIT_WIDTH button vector onto pmod_data/pmod_clk/pmod_latch in the exact framing our gamepad_pmod_driver/gamepad_pmod_decoder pair consumes.

---
 rtl/gamepad_pmod_pkg.sv | 32 +++
 rtl/gamepad_pmod_transmitter_if.sv | 25 ++
 rtl/pmod_half_period_timer.sv | 42 ++++
 rtl/gamepad_pmod_transmitter.sv | 124 ++++++++++++
 tb/tb_gamepad_pmod_transmitter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gamepad_pmod_pkg.sv
// rtl/gamepad_pmod_pkg.sv - shared constants, state type and width helper for the gamepad PMOD link
package gamepad_pmod_pkg;

    localparam int GAMEPAD_BITS = 12;

    // Bit positions in the button vector; the first serial bit lands in BTN_B.
    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_LATCH
    } pmod_tx_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gamepad_pmod_transmitter_if.sv
// rtl/gamepad_pmod_transmitter_if.sv - button input and 3-wire PMOD output bundle
interface gamepad_pmod_transmitter_if
    import gamepad_pmod_pkg::*;
#(
    parameter int BIT_WIDTH = GAMEPAD_BITS
);
    logic                 enable;
    logic [BIT_WIDTH-1:0] buttons;
    logic                 present;
    logic                 pmod_clk;
    logic                 pmod_latch;
    logic                 pmod_data;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  enable, buttons, present,
        output pmod_clk, pmod_latch, pmod_data, busy, frame_done
    );

    modport slave (
        output enable, buttons, present,
        input  pmod_clk, pmod_latch, pmod_data, busy, frame_done
    );
endinterface

// File: rtl/pmod_half_period_timer.sv
// rtl/pmod_half_period_timer.sv - one-shot timer: expire pulses CLK_DIV cycles after start
module pmod_half_period_timer
    import gamepad_pmod_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic expire
);
    localparam int              CW       = cnt_width(CLK_DIV - 1);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        expire = run_q && (cnt_q == '0);
        cnt_d  = cnt_q;
        run_d  = run_q;
        // A restart on the expiring cycle lets back-to-back states chain without a gap.
        if (start) begin
            cnt_d = LOAD_VAL;
            run_d = 1'b1;
        end else if (expire) begin
            run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/gamepad_pmod_transmitter.sv
// rtl/gamepad_pmod_transmitter.sv - serialises a button vector onto pmod_data/pmod_clk/pmod_latch
module gamepad_pmod_transmitter
    import gamepad_pmod_pkg::*;
#(
    parameter int BIT_WIDTH  = GAMEPAD_BITS,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    gamepad_pmod_transmitter_if.master   bus
);
    generate
        if (CLK_DIV < 2 || BIT_WIDTH < 1) begin : g_bad_params
            $fatal(1, "gamepad_pmod_transmitter: CLK_DIV must be >= 2 and BIT_WIDTH >= 1");
        end
    endgenerate

    localparam int BW = cnt_width(BIT_WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES);

    pmod_tx_state_e       state_q, state_d;
    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 pmod_clk_q, pmod_clk_d;
    logic                 pmod_latch_q, pmod_latch_d;
    logic                 pmod_data_q, pmod_data_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 timer_start;
    logic                 timer_expire;

    pmod_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (timer_start),
        .expire (timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_d        = gap_q;
        frame_done_d = 1'b0;
        timer_start  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (bus.enable) begin
                    // Snapshot here so the whole frame ignores later input changes.
                    state_d   = ST_LOAD;
                    shift_d   = bus.present ? bus.buttons : '1;
                    bit_cnt_d = BW'(BIT_WIDTH);
                end
            end
            ST_LOAD: begin
                state_d     = ST_BIT_LO;
                timer_start = 1'b1;
            end
            ST_BIT_LO: begin
                if (timer_expire) begin
                    state_d     = ST_BIT_HI;
                    timer_start = 1'b1;
                end
            end
            ST_BIT_HI: begin
                if (timer_expire) begin
                    shift_d     = shift_q << 1;
                    bit_cnt_d   = bit_cnt_q - 1'b1;
                    state_d     = (bit_cnt_q == BW'(1)) ? ST_LATCH : ST_BIT_LO;
                    timer_start = 1'b1;
                end
            end
            ST_LATCH: begin
                if (timer_expire) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    gap_d        = GW'(GAP_CYCLES);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pins are decoded from the next state so they stay aligned with state_q once registered.
        pmod_clk_d   = (state_d == ST_BIT_HI);
        pmod_latch_d = (state_d == ST_LATCH);
        pmod_data_d  = (state_d == ST_BIT_LO || state_d == ST_BIT_HI) ? shift_d[BIT_WIDTH-1] : 1'b1;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '1;
            bit_cnt_q    <= '0;
            gap_q        <= '0;
            pmod_clk_q   <= 1'b0;
            pmod_latch_q <= 1'b0;
            pmod_data_q  <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_q        <= gap_d;
            pmod_clk_q   <= pmod_clk_d;
            pmod_latch_q <= pmod_latch_d;
            pmod_data_q  <= pmod_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pmod_clk   = pmod_clk_q;
    assign bus.pmod_latch = pmod_latch_q;
    assign bus.pmod_data  = pmod_data_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_gamepad_pmod_transmitter.sv
// tb/tb_gamepad_pmod_transmitter.sv - randomized bench with frame-position model and loopback receiver
module tb_gamepad_pmod_transmitter;
    localparam int W    = 12;
    localparam int C1   = 4;
    localparam int G1   = 16;
    localparam int C2   = 2;
    localparam int G2   = 0;
    localparam int LAST = 2 * C1 * W + C1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    gamepad_pmod_transmitter_if #(.BIT_WIDTH(W)) if1 ();
    gamepad_pmod_transmitter_if #(.BIT_WIDTH(W)) if2 ();

    gamepad_pmod_transmitter #(.BIT_WIDTH(W), .CLK_DIV(C1), .GAP_CYCLES(G1)) dut1 (
        .clk(clk), .reset(rst), .bus(if1.master));
    gamepad_pmod_transmitter #(.BIT_WIDTH(W), .CLK_DIV(C2), .GAP_CYCLES(G2)) dut2 (
        .clk(clk), .reset(rst2), .bus(if2.master));

    // Model: either idle with a gap count, or at position k (0 = LOAD) inside a frame.
    bit           m_in, m_fd;
    int           m_k, m_gap;
    logic [W-1:0] m_frame;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in <= 1'b0; m_fd <= 1'b0; m_k <= 0; m_gap <= 0;
        end else if (m_in) begin
            if (m_k == LAST) begin
                m_in <= 1'b0; m_gap <= G1; m_fd <= 1'b1;
            end else begin
                m_k <= m_k + 1;
            end
        end else begin
            m_fd <= 1'b0;
            if (m_gap == 0 && if1.enable) begin
                m_in    <= 1'b1;
                m_k     <= 0;
                m_frame <= if1.present ? if1.buttons : '1;
            end else if (m_gap > 0) begin
                m_gap <= m_gap - 1;
            end
        end
    end

    // Expected {pmod_clk, pmod_latch, pmod_data, busy, frame_done}.
    function automatic logic [4:0] exp_out(input bit in_frame, input int k, input logic [W-1:0] fr, input bit fd);
        logic [4:0] e;
        int j;
        e = {4'b0010, fd};
        if (in_frame) begin
            e = 5'b00110;
            if (k >= 1 && k <= 2 * C1 * W) begin
                j    = k - 1;
                e[4] = ((j / C1) % 2) == 1;
                e[2] = fr[W - 1 - j / (2 * C1)];
            end else if (k > 2 * C1 * W) begin
                e[3] = 1'b1;
            end
        end
        return e;
    endfunction

    int n_tests, n_fail, cyc;
    int rise1, rise2, load_cyc, last_fd2, stab2, quiet;
    logic prev_c1, prev_l1, prev_b1, prev_c2, prev_l2, prev_d2;
    logic [W-1:0] rx_sh1, rx1, rx_sh2, rx2;
    bit b1_rise;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("model", 32'({if1.pmod_clk, if1.pmod_latch, if1.pmod_data, if1.busy, if1.frame_done}),
            32'(exp_out(m_in, m_k, m_frame, m_fd)));
        if (rst) begin
            rise1 = 0;
        end else begin
            if (if1.pmod_clk && !prev_c1) begin
                rx_sh1 = {rx_sh1[W-2:0], if1.pmod_data};
                rise1++;
            end
            if (if1.pmod_latch && !prev_l1) begin
                chk("rises1", 32'(rise1), 32'(W));
                rx1   = rx_sh1;
                rise1 = 0;
            end
        end
        b1_rise = if1.busy && !prev_b1;
        if (b1_rise) load_cyc = cyc;
        if (if1.frame_done) chk("frame_len", 32'(cyc - load_cyc), 32'd101);
        if (!rst2) begin
            if (if2.pmod_data !== prev_d2) begin
                chk("hold2", 32'(if2.pmod_clk), 32'd0);
                stab2 = 1;
            end else begin
                if (if2.pmod_clk && !prev_c2) chk("setup2", 32'(stab2 >= 2), 32'd1);
                stab2++;
            end
            if (if2.pmod_clk && !prev_c2) begin
                rx_sh2 = {rx_sh2[W-2:0], if2.pmod_data};
                rise2++;
            end
            if (if2.pmod_latch && !prev_l2) begin
                chk("rises2", 32'(rise2), 32'(W));
                rx2   = rx_sh2;
                rise2 = 0;
            end
            if (if2.frame_done) begin
                if (last_fd2 >= 0) chk("period2", 32'(cyc - last_fd2), 32'd52);
                last_fd2 = cyc;
                chk("rx2", 32'(rx2), 32'h5A3);
            end
        end
        prev_c1 = if1.pmod_clk;  prev_l1 = if1.pmod_latch; prev_b1 = if1.busy;
        prev_c2 = if2.pmod_clk;  prev_l2 = if2.pmod_latch; prev_d2 = if2.pmod_data;
    endtask

    task automatic wait_fd(input int lim);
        int i;
        i = 0;
        do begin tick(); i++; end while (!if1.frame_done && i < lim);
        if (!if1.frame_done) chk("timeout_frame_done", 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input int lim);
        int i;
        i = 0;
        do begin tick(); i++; end while (!b1_rise && i < lim);
        if (!b1_rise) chk("timeout_load", 32'd0, 32'd1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; rise1 = 0; rise2 = 0; load_cyc = 0;
        last_fd2 = -1; stab2 = 0; quiet = 0;
        prev_c1 = 0; prev_l1 = 0; prev_b1 = 0; prev_c2 = 0; prev_l2 = 0; prev_d2 = 1;
        rx_sh1 = '0; rx1 = '0; rx_sh2 = '0; rx2 = '0;
        if1.enable = 0; if1.present = 1; if1.buttons = '0;
        if2.enable = 1; if2.present = 1; if2.buttons = 12'h5A3;
        repeat (3) tick();
        chk("reset_state", 32'({if1.pmod_clk, if1.pmod_latch, if1.pmod_data, if1.busy, if1.frame_done}), 32'b00100);
        rst = 0; rst2 = 0;

        if1.enable = 1; if1.buttons = 12'b1000_0000_1000;
        wait_fd(300);
        chk("loop_rx", 32'(rx1), 32'h808);
        chk("loop_present", 32'(rx1 != 12'hFFF), 32'd1);

        if1.present = 0; if1.buttons = 12'hABC;
        wait_fd(300);
        chk("absent_rx", 32'(rx1), 32'hFFF);
        chk("absent_present", 32'(rx1 != 12'hFFF), 32'd0);

        repeat (3000) begin
            tick();
            if ($urandom_range(0, 39) == 0)  if1.buttons = W'($urandom);
            if ($urandom_range(0, 59) == 0)  if1.present = ~if1.present;
            if ($urandom_range(0, 249) == 0) if1.enable  = ~if1.enable;
        end

        if1.enable = 1; if1.present = 1; if1.buttons = 12'h001;
        wait_fd(400);
        wait_busy(100);
        repeat (1 + 5 * 2 * C1 + 2) tick();
        if1.buttons = 12'h800;
        wait_fd(200);
        chk("inflight_rx", 32'(rx1), 32'h001);
        wait_fd(200);
        chk("next_rx", 32'(rx1), 32'h800);

        wait_busy(100);
        repeat (1 + 3 * 2 * C1 + 2) tick();
        if1.enable = 0;
        wait_fd(200);
        repeat (500) begin
            tick();
            if (if1.pmod_clk || if1.busy || if1.pmod_latch) quiet++;
        end
        chk("idle_quiet", 32'(quiet), 32'd0);

        if1.buttons = 12'h3C3; if1.enable = 1;
        wait_fd(200);
        chk("pre_reset_rx", 32'(rx1), 32'h3C3);
        wait_busy(100);
        repeat (1 + 7 * 2 * C1 + 2) tick();
        rst = 1; if1.buttons = 12'h0F0;
        tick();
        chk("rst_idle", 32'({if1.pmod_clk, if1.pmod_latch, if1.pmod_data, if1.busy, if1.frame_done}), 32'b00100);
        rst = 0;
        chk("rx_kept", 32'(rx1), 32'h3C3);
        wait_fd(300);
        chk("post_reset_rx", 32'(rx1), 32'h0F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
